// File: rtl/srambank_pkg.sv
// Shared defaults and elaboration helpers for the srambank request front-end.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package srambank_pkg;

    // Default geometry, matching the srambank macro this block feeds.
    localparam int ADDRESS_DEFAULT    = 9;
    localparam int DATA_DEFAULT       = 18;
    localparam int BANKS_DEFAULT      = 4;
    localparam int RESP_DEPTH_DEFAULT = 3;

    // Ceiling log2 for sizing indices and counters at elaboration time.
    // Returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of bits needed to hold a count in 0..value inclusive.
    function automatic int count_bits(input int value);
        return clog2(value + 1);
    endfunction

endpackage : srambank_pkg

// File: rtl/srambank_resp_fifo.sv
// In-order synchronous response FIFO; read data is the combinational head entry.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller meters pushes by credit.
module srambank_resp_fifo
    import srambank_pkg::*;
#(
    parameter int DATA  = DATA_DEFAULT,
    parameter int DEPTH = RESP_DEPTH_DEFAULT,
    localparam int PW   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CW   = count_bits(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic [DATA-1:0] i_push_data,
    input  logic            i_pop,
    output logic [DATA-1:0] o_pop_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [CW-1:0]   o_count
);

    logic [DATA-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full     = (count == CW'(DEPTH));
    assign o_empty    = (count == '0);
    assign o_count    = count;
    assign o_pop_data = mem[rd_ptr];
    assign do_push    = i_push & ~o_full;
    assign do_pop     = i_pop & ~o_empty;

    // Storage array: written on an accepted push, never reset (contents are don't-care when empty).
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : srambank_resp_fifo

// File: rtl/srambank_ctrl.sv
// Request front-end for an array of srambanks: decodes a flat address, drives the shared bank bus, queues read data.
// Latency: bank drive is combinational on fire; read data reaches o_resp_valid 2 cycles after fire when the FIFO is empty.
// Backpressure: o_req_ready drops (for reads and writes) once FIFO occupancy plus an in-flight read reaches RESP_DEPTH.
module srambank_ctrl
    import srambank_pkg::*;
#(
    parameter int ADDRESS    = ADDRESS_DEFAULT,
    parameter int DATA       = DATA_DEFAULT,
    parameter int BANKS      = BANKS_DEFAULT,
    parameter int RESP_DEPTH = RESP_DEPTH_DEFAULT,
    localparam int BANK_BITS = clog2(BANKS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic                         i_req_write,
    input  logic [BANK_BITS+ADDRESS-1:0] i_req_addr,
    input  logic [DATA-1:0]              i_req_wdata,
    output logic                         o_resp_valid,
    input  logic                         i_resp_ready,
    output logic [DATA-1:0]              o_resp_data,
    output logic [ADDRESS-1:0]           o_bank_address,
    output logic [DATA-1:0]              o_bank_write_data,
    output logic [BANKS-1:0]             o_bank_sel,
    output logic                         o_bank_read_en,
    output logic                         o_bank_write_en,
    input  logic [BANKS*DATA-1:0]        i_bank_data
);

    localparam int CW = count_bits(RESP_DEPTH);

    // Geometry the decode and credit logic rely on.
    if (BANKS < 2 || (1 << BANK_BITS) != BANKS) begin : g_bad_banks
        $error("srambank_ctrl: BANKS must be a power of two >= 2");
    end
    if (RESP_DEPTH < 3) begin : g_bad_depth
        $error("srambank_ctrl: RESP_DEPTH must be >= 3 for full read throughput");
    end

    // Request decode.
    logic [BANK_BITS-1:0] req_bank;
    logic [ADDRESS-1:0]   req_bank_addr;
    logic                 req_fire;
    logic                 rd_fire;

    // Read in flight: the bank has been strobed and its data is on i_bank_data this cycle.
    logic                 rd_pend;
    logic [BANK_BITS-1:0] rd_bank;

    // Response path.
    logic [DATA-1:0]      bank_words [BANKS];
    logic [DATA-1:0]      rd_word;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        occ;
    logic [CW:0]          inflight;

    assign req_bank      = i_req_addr[ADDRESS +: BANK_BITS];
    assign req_bank_addr = i_req_addr[ADDRESS-1:0];
    assign req_fire      = i_req_valid & o_req_ready;
    assign rd_fire       = req_fire & ~i_req_write;

    // Every accepted read needs a FIFO slot by the time its data lands, so the
    // in-flight read counts against capacity alongside the queued entries.
    // Writes share the rule so request order is never bypassed.
    assign inflight    = {1'b0, occ} + (CW+1)'(rd_pend);
    assign o_req_ready = ~i_rst & (inflight < (CW+1)'(RESP_DEPTH));

    // Bank bus: address/data always follow the request; select and strobes only on fire.
    always_comb begin
        o_bank_address    = req_bank_addr;
        o_bank_write_data = i_req_wdata;
        o_bank_sel        = '0;
        o_bank_read_en    = 1'b0;
        o_bank_write_en   = 1'b0;
        if (req_fire) begin
            o_bank_sel      = BANKS'(1) << req_bank;
            o_bank_write_en = i_req_write;
            o_bank_read_en  = ~i_req_write;
        end
    end

    // Track the read whose data arrives next cycle; reloads on back-to-back reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pend <= 1'b0;
            rd_bank <= '0;
        end else begin
            rd_pend <= rd_fire;
            if (rd_fire) begin
                rd_bank <= req_bank;
            end
        end
    end

    // Split the flat bank data bus into per-bank words.
    for (genvar k = 0; k < BANKS; k++) begin : g_bank_words
        assign bank_words[k] = i_bank_data[k*DATA +: DATA];
    end

    assign rd_word      = bank_words[rd_bank];
    // Credit already guarantees room; the full term only keeps a broken
    // upstream from overwriting the queue.
    assign fifo_push    = rd_pend & ~fifo_full;
    assign fifo_pop     = o_resp_valid & i_resp_ready;
    assign o_resp_valid = ~fifo_empty;

    srambank_resp_fifo #(
        .DATA  (DATA),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (fifo_push),
        .i_push_data (rd_word),
        .i_pop       (fifo_pop),
        .o_pop_data  (o_resp_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (occ)
    );

endmodule : srambank_ctrl

// File: tb/tb_srambank_ctrl.sv
// Directed bench for srambank_ctrl with a behavioural model of four srambanks on the bank bus.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 2 units after posedge.
// Backpressure: i_resp_ready driven per scenario to exercise credit stalls.
module tb_srambank_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [10:0] req_addr;
    logic [17:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [17:0] resp_data;
    logic [8:0]  bank_address;
    logic [17:0] bank_write_data;
    logic [3:0]  bank_sel;
    logic        bank_read_en;
    logic        bank_write_en;
    logic [71:0] bank_data;

    int n_total;
    int n_pass;
    int inv_errors;

    srambank_ctrl dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_write       (req_write),
        .i_req_addr        (req_addr),
        .i_req_wdata       (req_wdata),
        .o_resp_valid      (resp_valid),
        .i_resp_ready      (resp_ready),
        .o_resp_data       (resp_data),
        .o_bank_address    (bank_address),
        .o_bank_write_data (bank_write_data),
        .o_bank_sel        (bank_sel),
        .o_bank_read_en    (bank_read_en),
        .o_bank_write_en   (bank_write_en),
        .i_bank_data       (bank_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four srambanks: write on the strobe edge, registered read data the next cycle.
    logic [17:0] bank_mem  [4][512];
    logic [17:0] bank_dout [4];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bank_sel[k] && bank_write_en) bank_mem[k][bank_address] <= bank_write_data;
            if (bank_sel[k] && bank_read_en)  bank_dout[k] <= bank_mem[k][bank_address];
        end
    end

    assign bank_data = {bank_dout[3], bank_dout[2], bank_dout[1], bank_dout[0]};

    // A read landing while the FIFO is full would be lost.
    always @(negedge clk) begin
        if (!rst && dut.rd_pend && dut.fifo_full) begin
            inv_errors++;
            $display("FAIL push_while_full: rd_pend=1 fifo_full=1 required never both at t=%0t", $time);
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] bank,
                         input logic [8:0] a, input logic [17:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = {bank, a};
        req_wdata = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        resp_ready = 1'b1;
        drive(1'b1, 1'b0, 2'd1, 9'h003, 18'h0);
        repeat (2) begin
            tick;
            #1;
            n_total++;
            if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", req_ready);
            else n_pass++;
            n_total++;
            if (bank_sel !== 4'b0000) $display("FAIL reset_sel: got %b required 0000", bank_sel);
            else n_pass++;
            n_total++;
            if ({bank_read_en, bank_write_en} !== 2'b00)
                $display("FAIL reset_enables: got %b required 00", {bank_read_en, bank_write_en});
            else n_pass++;
            n_total++;
            if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b required 0", resp_valid);
            else n_pass++;
        end
        tick;
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 9'h0, 18'h0);
        #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL post_reset_ready: got %b required 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_write_read;
        resp_ready = 1'b1;
        tick;
        drive(1'b1, 1'b1, 2'd2, 9'h005, 18'h2A5A5);
        #1;
        n_total++;
        if ({bank_sel, bank_write_en, bank_read_en} !== 6'b0100_10)
            $display("FAIL wr_drive: got sel=%b we=%b re=%b required sel=0100 we=1 re=0",
                     bank_sel, bank_write_en, bank_read_en);
        else n_pass++;
        n_total++;
        if ({bank_address, bank_write_data} !== {9'h005, 18'h2A5A5})
            $display("FAIL wr_bus: got addr=%h data=%h required 005/2a5a5", bank_address, bank_write_data);
        else n_pass++;
        tick;
        drive(1'b1, 1'b0, 2'd2, 9'h005, 18'h0);
        #1;
        n_total++;
        if ({bank_sel, bank_write_en, bank_read_en} !== 6'b0100_01)
            $display("FAIL rd_drive: got sel=%b we=%b re=%b required sel=0100 we=0 re=1",
                     bank_sel, bank_write_en, bank_read_en);
        else n_pass++;
        tick;
        drive(1'b0, 1'b0, 2'd0, 9'h0, 18'h0);
        #1;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rd_latency_t1: got valid=%b required 0", resp_valid);
        else n_pass++;
        n_total++;
        if ({bank_sel, bank_read_en, bank_write_en} !== 6'b0)
            $display("FAIL idle_drive: got sel=%b re=%b we=%b required all 0",
                     bank_sel, bank_read_en, bank_write_en);
        else n_pass++;
        tick;
        #1;
        n_total++;
        if ({resp_valid, resp_data} !== {1'b1, 18'h2A5A5})
            $display("FAIL rd_latency_t2: got valid=%b data=%h required 1/2a5a5", resp_valid, resp_data);
        else n_pass++;
        tick;
        #1;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rd_popped: got valid=%b required 0", resp_valid);
        else n_pass++;
    endtask

    task automatic test_streaming;
        logic [17:0] exp_val;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            drive(1'b1, 1'b1, 2'(k), 9'h010, 18'(k + 1));
        end
        for (int i = 0; i < 6; i++) begin
            tick;
            if (i < 4) drive(1'b1, 1'b0, 2'(i), 9'h010, 18'h0);
            else drive(1'b0, 1'b0, 2'd0, 9'h0, 18'h0);
            #1;
            if (i < 4) begin
                n_total++;
                if (req_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b required 1", i, req_ready);
                else n_pass++;
            end
            if (i >= 2) begin
                exp_val = 18'(i - 1);
                n_total++;
                if ({resp_valid, resp_data} !== {1'b1, exp_val})
                    $display("FAIL stream_resp[%0d]: got valid=%b data=%h required 1/%h",
                             i, resp_valid, resp_data, exp_val);
                else n_pass++;
            end
        end
        tick;
        #1;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL stream_drained: got valid=%b required 0", resp_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [17:0] exp_data [5];
        logic [1:0]  rd_banks [5];
        int acc;
        int got;
        exp_data = '{18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h00001};
        rd_banks = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        acc = 0;
        got = 0;
        resp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (c == 4) begin
                drive(1'b1, 1'b1, 2'd3, 9'h020, 18'h12345);
                #1;
                n_total++;
                if ({req_ready, bank_write_en, bank_sel} !== 6'b0)
                    $display("FAIL bp_write_stalled: got ready=%b we=%b sel=%b required all 0",
                             req_ready, bank_write_en, bank_sel);
                else n_pass++;
            end else begin
                drive(1'b1, 1'b0, rd_banks[acc], 9'h010, 18'h0);
                #1;
                if (req_ready) acc++;
            end
        end
        n_total++;
        if (acc !== 3) $display("FAIL bp_accepted: got %0d required 3", acc);
        else n_pass++;
        n_total++;
        if ({resp_valid, req_ready} !== 2'b10)
            $display("FAIL bp_full_state: got valid=%b ready=%b required 1/0", resp_valid, req_ready);
        else n_pass++;
        for (int c = 0; c < 16; c++) begin
            tick;
            resp_ready = 1'b1;
            if (acc < 5) drive(1'b1, 1'b0, rd_banks[acc], 9'h010, 18'h0);
            else drive(1'b0, 1'b0, 2'd0, 9'h0, 18'h0);
            #1;
            if (resp_valid) begin
                n_total++;
                if (got >= 5) $display("FAIL bp_extra_resp: got data=%h required none", resp_data);
                else if (resp_data !== exp_data[got])
                    $display("FAIL bp_order[%0d]: got %h required %h", got, resp_data, exp_data[got]);
                else n_pass++;
                got++;
            end
            if (req_valid && req_ready) acc++;
        end
        n_total++;
        if (got !== 5 || acc !== 5)
            $display("FAIL bp_totals: got responses=%0d accepted=%0d required 5/5", got, acc);
        else n_pass++;
    endtask

    task automatic test_mixed;
        logic [17:0] exp_data [2];
        int got;
        exp_data = '{18'h00002, 18'h3FFFF};
        got = 0;
        resp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick;
            case (c)
                0:       drive(1'b1, 1'b0, 2'd1, 9'h010, 18'h0);
                1:       drive(1'b1, 1'b1, 2'd1, 9'h010, 18'h3FFFF);
                2:       drive(1'b1, 1'b0, 2'd1, 9'h010, 18'h0);
                default: drive(1'b0, 1'b0, 2'd0, 9'h0, 18'h0);
            endcase
            #1;
            if (resp_valid) begin
                n_total++;
                if (got >= 2) $display("FAIL mixed_extra_resp: got data=%h required none", resp_data);
                else if (resp_data !== exp_data[got])
                    $display("FAIL mixed_order[%0d]: got %h required %h", got, resp_data, exp_data[got]);
                else n_pass++;
                got++;
            end
        end
        n_total++;
        if (got !== 2) $display("FAIL mixed_count: got %0d responses required 2", got);
        else n_pass++;
    endtask

    task automatic test_reset_midflight;
        resp_ready = 1'b1;
        tick;
        drive(1'b1, 1'b0, 2'd2, 9'h005, 18'h0);
        #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL mf_fire_ready: got %b required 1", req_ready);
        else n_pass++;
        tick;
        drive(1'b0, 1'b0, 2'd0, 9'h0, 18'h0);
        rst = 1'b1;
        #1;
        n_total++;
        if ({resp_valid, req_ready} !== 2'b00)
            $display("FAIL mf_in_reset: got valid=%b ready=%b required 0/0", resp_valid, req_ready);
        else n_pass++;
        tick;
        rst = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if ({resp_valid, req_ready} !== 2'b01)
                $display("FAIL mf_after_reset[%0d]: got valid=%b ready=%b required 0/1", c, resp_valid, req_ready);
            else n_pass++;
            tick;
            #1;
        end
        n_total++;
        if (dut.occ !== 2'd0) $display("FAIL mf_occ: got %0d required 0", dut.occ);
        else n_pass++;
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        inv_errors = 0;
        rst        = 1'b1;
        resp_ready = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 9'h0, 18'h0);
        test_reset;
        test_write_read;
        test_streaming;
        test_backpressure;
        test_mixed;
        test_reset_midflight;
        n_total++;
        if (inv_errors != 0) $display("FAIL push_while_full_total: got %0d violations required 0", inv_errors);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_srambank_ctrl
